multicycle_control_unit: RTL

Multi-cycle RV32I control FSM. It is the sequential successor to the single-cycle opcode decoder. It sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a req/ack handshake. The 15-bit control word for the current instruction is held in a register, and the write enables are gated per state. It sits between the instruction register and the datapath muxes, the register file and the memory interface.

---
 rtl/mcu_pkg.sv | 47 ++++
 rtl/mcu_decoder.sv | 27 ++
 rtl/multicycle_control_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit:
// FSM state encoding, opcode values and the 15-bit control word.
package mcu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic       memw;
        logic       branch;
        logic       memrd;
        logic       regwrite;
        logic       memtoreg;
        logic       opbsel;
        logic [2:0] aluop;
        logic [1:0] opasel;
        logic [1:0] extendsel;
        logic [1:0] nextpcsel;
    } cw_t;

    localparam cw_t CW_NOP    = 15'h0000;
    localparam cw_t CW_RTYPE  = 15'h0800;
    localparam cw_t CW_LOAD   = 15'h1F00;
    localparam cw_t CW_STORE  = 15'h4348;
    localparam cw_t CW_BRANCH = 15'h2081;
    localparam cw_t CW_ITYPE  = 15'h0A40;
    localparam cw_t CW_JALR   = 15'h0AE3;
    localparam cw_t CW_JAL    = 15'h08E2;
    localparam cw_t CW_LUI    = 15'h0BB4;

endpackage

// File: rtl/mcu_decoder.sv
// Combinational opcode decoder: maps instr[6:0] to a control word and a
// legal flag. Unknown opcodes produce an all-zero (NOP) control word.
module mcu_decoder
    import mcu_pkg::*;
(
    input  logic [6:0] i_opcode,
    output cw_t        o_cw,
    output logic       o_legal
);

    always_comb begin
        o_cw    = CW_NOP;
        o_legal = 1'b1;
        case (i_opcode)
            OP_RTYPE:  o_cw = CW_RTYPE;
            OP_LOAD:   o_cw = CW_LOAD;
            OP_STORE:  o_cw = CW_STORE;
            OP_BRANCH: o_cw = CW_BRANCH;
            OP_ITYPE:  o_cw = CW_ITYPE;
            OP_JALR:   o_cw = CW_JALR;
            OP_JAL:    o_cw = CW_JAL;
            OP_LUI:    o_cw = CW_LUI;
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a
// shared req/ack memory port. Define MCU_ILLEGAL_TRAP_EN to trap on unknown opcodes.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      instr_i,
    input  logic             mem_ack_i,
    input  logic             branch_taken_i,
    input  logic             stall_i,
    output logic             mem_req_o,
    output logic             mem_iord_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             memw_o,
    output logic             branch_o,
    output logic             memrd_o,
    output logic             regwrite_o,
    output logic             memtoreg_o,
    output logic             opBsel_o,
    output logic [2:0]       aluop_o,
    output logic [1:0]       opAsel_o,
    output logic [1:0]       extendsel_o,
    output logic [1:0]       nextPCsel_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             fault_o,
    output logic             illegal_o,
    output logic             trap_o
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t            r_state, w_state_next;
    cw_t               r_cw, w_dec_cw;
    logic [CNT_W-1:0]  r_instret;
    logic              r_fault;
    logic [TO_W-1:0]   r_to_cnt, w_to_next;
    logic              w_dec_legal, w_halt;
    logic              w_req, w_iord, w_ir_we, w_pc_we, w_trap, w_retire, w_cw_load;
    logic              w_to_tick, w_to_clr, w_fault_set;
    logic              w_wb_en, w_mem_en, w_br_en;
    logic              w_is_mem, w_is_jump;
    logic              w_unused;
`ifdef MCU_ILLEGAL_TRAP_EN
    logic              r_illegal, w_ill_set, w_ill_clr;
`endif

    assign w_unused = ^instr_i[31:7];

    mcu_decoder u_decoder (
        .i_opcode (instr_i[6:0]),
        .o_cw     (w_dec_cw),
        .o_legal  (w_dec_legal)
    );

    // Instruction class is recovered from the latched word, so EXEC/MEM never look at instr_i.
    assign w_is_mem  = r_cw.memw | r_cw.memrd;
    assign w_is_jump = !r_cw.branch && (r_cw.nextpcsel != 2'b00);
    assign w_to_next = r_to_cnt + TO_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_iord       = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_trap       = 1'b0;
        w_retire     = 1'b0;
        w_cw_load    = 1'b0;
        w_to_tick    = 1'b0;
        w_to_clr     = 1'b0;
        w_fault_set  = 1'b0;
        w_wb_en      = 1'b0;
        w_mem_en     = 1'b0;
        w_br_en      = 1'b0;
`ifdef MCU_ILLEGAL_TRAP_EN
        w_ill_set    = 1'b0;
        w_ill_clr    = 1'b0;
`endif
        case (r_state)
            FETCH: begin
                w_req = 1'b1;
                if (mem_ack_i) begin
                    w_ir_we      = 1'b1;
                    w_pc_we      = 1'b1;
                    w_to_clr     = 1'b1;
                    w_state_next = DECODE;
                end else begin
                    w_to_tick = 1'b1;
                end
            end
            DECODE: begin
                w_cw_load = 1'b1;
                if (!stall_i) begin
                    if (w_dec_legal) begin
                        w_state_next = EXEC;
`ifdef MCU_ILLEGAL_TRAP_EN
                        w_ill_clr    = 1'b1;
`endif
                    end else begin
`ifdef MCU_ILLEGAL_TRAP_EN
                        w_state_next = TRAP;
                        w_ill_set    = 1'b1;
`else
                        w_state_next = FETCH;
`endif
                    end
                end
            end
            EXEC: begin
                w_br_en = 1'b1;
                if (!stall_i) begin
                    if (r_cw.branch) begin
                        w_pc_we      = branch_taken_i;
                        w_retire     = 1'b1;
                        w_state_next = FETCH;
                    end else if (w_is_mem) begin
                        w_state_next = MEM;
                    end else begin
                        w_pc_we      = w_is_jump;
                        w_state_next = WB;
                    end
                end
            end
            MEM: begin
                w_req    = 1'b1;
                w_iord   = 1'b1;
                w_mem_en = 1'b1;
                if (mem_ack_i) begin
                    w_to_clr = 1'b1;
                    if (r_cw.memrd) begin
                        w_state_next = WB;
                    end else begin
                        w_retire     = 1'b1;
                        w_state_next = FETCH;
                    end
                end else begin
                    w_to_tick = 1'b1;
                end
            end
            WB: begin
                if (!stall_i) begin
                    w_wb_en      = 1'b1;
                    w_retire     = 1'b1;
                    w_state_next = FETCH;
                end
            end
`ifdef MCU_ILLEGAL_TRAP_EN
            TRAP: begin
                w_trap       = 1'b1;
                w_pc_we      = 1'b1;
                w_state_next = FETCH;
            end
`endif
            HALT: w_state_next = HALT;
            default: w_state_next = FETCH;
        endcase
        if (w_to_tick && (TIMEOUT != 0) && (w_to_next == TO_W'(TIMEOUT))) begin
            w_state_next = HALT;
            w_fault_set  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= FETCH;
            r_cw      <= CW_NOP;
            r_instret <= '0;
            r_fault   <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_cw_load)   r_cw      <= w_dec_cw;
            if (w_retire)    r_instret <= r_instret + CNT_W'(1);
            if (w_fault_set) r_fault   <= 1'b1;
            if (w_to_clr)        r_to_cnt <= '0;
            else if (w_to_tick)  r_to_cnt <= w_to_next;
        end
    end

`ifdef MCU_ILLEGAL_TRAP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        r_illegal <= 1'b0;
        else if (w_ill_set) r_illegal <= 1'b1;
        else if (w_ill_clr) r_illegal <= 1'b0;
    end
    assign illegal_o = r_illegal & !w_halt;
`else
    assign illegal_o = 1'b0;
`endif

    assign w_halt = (r_state == HALT);

    // Input-driven strobes are masked by reset so the bus request drops asynchronously.
    assign mem_req_o   = rst_ni & w_req;
    assign mem_iord_o  = rst_ni & w_iord;
    assign ir_we_o     = rst_ni & w_ir_we;
    assign pc_we_o     = rst_ni & w_pc_we;
    assign trap_o      = rst_ni & w_trap;

    assign regwrite_o  = w_wb_en  & r_cw.regwrite;
    assign memw_o      = w_mem_en & r_cw.memw;
    assign memrd_o     = w_mem_en & r_cw.memrd;
    assign branch_o    = w_br_en  & r_cw.branch;
    assign memtoreg_o  = !w_halt & r_cw.memtoreg;
    assign opBsel_o    = !w_halt & r_cw.opbsel;
    assign aluop_o     = w_halt ? 3'b000 : r_cw.aluop;
    assign opAsel_o    = w_halt ? 2'b00 : r_cw.opasel;
    assign extendsel_o = w_halt ? 2'b00 : r_cw.extendsel;
    assign nextPCsel_o = (w_halt || r_state == FETCH) ? 2'b00 : r_cw.nextpcsel;

    assign state_o     = r_state;
    assign instret_o   = w_halt ? '0 : r_instret;
    assign fault_o     = r_fault;

endmodule
